// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
// One shared shift-add / restoring-divide datapath, stalls the pipe while busy.
// Ports: req_* (op, operands, rd tag in), resp_* (result, tag out),
//        flush (kill in-flight op), stall (hold IF/ID/EX).
// Optional MULDIV_FUSE_EN: one-entry cache of the last divide quo/rem.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_rd,
  input  logic             flush,
  output logic             stall,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_rd
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nx;

  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic              sa, sb;
  logic [XLEN-1:0]   dsr;
  logic [2*XLEN-1:0] acc;

  logic              accept, is_div, is_rem;
  logic              sgn_a, sgn_b, a_neg, b_neg;
  logic              b_zero, ovf, hit, direct;
  logic [XLEN-1:0]   mag_a, mag_b, spec_res, hit_res, direct_res;

  assign req_ready  = (state == IDLE);
  assign stall      = (state != IDLE);
  assign resp_valid = (state == DONE);
  assign accept     = req_valid & req_ready & ~flush;

  assign is_div = req_funct3[2];
  assign is_rem = req_funct3[2] & req_funct3[1];

  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (req_funct3)
      3'd1, 3'd4, 3'd6: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      3'd2:    sgn_a = 1'b1;
      default: ;
    endcase
  end

  assign a_neg = sgn_a & req_a[XLEN-1];
  assign b_neg = sgn_b & req_b[XLEN-1];
  assign mag_a = a_neg ? -req_a : req_a;
  assign mag_b = b_neg ? -req_b : req_b;

  assign b_zero = (req_b == '0);
  assign ovf    = is_div & ~req_funct3[0]
                & (req_a == MIN_V) & (&req_b);

  always_comb begin
    spec_res = is_rem ? '0 : MIN_V;
    if (b_zero)
      spec_res = is_rem ? req_a : '1;
  end

  assign direct     = is_div & (b_zero | ovf | hit);
  assign direct_res = (b_zero | ovf) ? spec_res : hit_res;

  // Shared iteration datapath; acc = {hi, lo}.
  // Multiply: hi accumulates, multiplier shifts out of lo.
  // Divide: hi is the partial remainder, quotient bits shift into lo.
  logic [XLEN:0]     add_s, sh_hi, sub_s;
  logic              q_bit;
  logic [2*XLEN-1:0] mul_nx, div_nx;

  assign add_s  = {1'b0, acc[2*XLEN-1:XLEN]}
                + (acc[0] ? {1'b0, dsr} : '0);
  assign mul_nx = {add_s, acc[XLEN-1:1]};

  // Remainder < divisor, so the 33-bit difference sign is exact.
  assign sh_hi  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign sub_s  = sh_hi - {1'b0, dsr};
  assign q_bit  = ~sub_s[XLEN];
  assign div_nx = {q_bit ? sub_s[XLEN-1:0] : sh_hi[XLEN-1:0],
                   acc[XLEN-2:0], q_bit};

  logic [2*XLEN-1:0] prod_f;
  logic [XLEN-1:0]   q_f, r_f, fix_res;

  assign prod_f  = (sa ^ sb) ? -acc : acc;
  assign q_f     = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign r_f     = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  assign fix_res = op[2] ? (op[1] ? r_f : q_f)
                 : (op[1:0] == 2'b00) ? prod_f[XLEN-1:0]
                 : prod_f[2*XLEN-1:XLEN];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = direct ? DONE : CALC;
      CALC: if (cnt == '0) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      op        <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      dsr       <= '0;
      acc       <= '0;
      resp_data <= '0;
      resp_rd   <= '0;
    end else if (accept) begin
      cnt     <= CW'(XLEN-1);
      op      <= req_funct3;
      sa      <= a_neg;
      sb      <= b_neg;
      resp_rd <= req_rd;
      dsr     <= is_div ? mag_b : mag_a;
      acc     <= {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
      if (direct) resp_data <= direct_res;
    end else if (state == CALC) begin
      acc <= op[2] ? div_nx : mul_nx;
      if (cnt != '0) cnt <= cnt - 1'b1;
    end else if (state == FIX) begin
      resp_data <= fix_res;
    end
  end

`ifdef MULDIV_FUSE_EN
  logic            cv, cs;
  logic [XLEN-1:0] ra, rb, ca, cb, cq, cr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cv <= 1'b0;
      cs <= 1'b0;
      ra <= '0;
      rb <= '0;
      ca <= '0;
      cb <= '0;
      cq <= '0;
      cr <= '0;
    end else begin
      if (accept) begin
        ra <= req_a;
        rb <= req_b;
      end
      if (flush || (accept && !is_div)) begin
        cv <= 1'b0;
      end else if (state == FIX && op[2]) begin
        cv <= 1'b1;
        ca <= ra;
        cb <= rb;
        cs <= ~op[0];
        cq <= q_f;
        cr <= r_f;
      end
    end
  end

  assign hit     = cv & is_div & (req_a == ca) & (req_b == cb)
                 & (cs == ~req_funct3[0]);
  assign hit_res = is_rem ? cr : cq;
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
- Accepts one M-extension op from EX, runs a shift-add multiply or a restoring divide over XLEN iterations, and returns the result with its rd tag for writeback.
- Drives the pipeline stall while busy, so one shared arithmetic datapath serves all M ops.

Parameters:
- XLEN, 32, operand/result width; iteration count per op.
- TAG_W, 5, width of rd tag carried with each op.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  EX presents an M op
- req_ready  output  1  block can accept (state IDLE)
- req_funct3  input  3  RV32M funct3: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7
- req_a  input  XLEN  rs1 value (already forwarded)
- req_b  input  XLEN  rs2 value (already forwarded)
- req_rd  input  TAG_W  destination register
- flush  input  1  kill in-flight op (branch mispredict/redirect)
- stall  output  1  hold IF/ID/EX; high whenever state is not IDLE
- resp_valid  output  1  result available
- resp_ready  input  1  writeback consumes result
- resp_data  output  XLEN  result
- resp_rd  output  TAG_W  tag of result

Behaviour:
- Reset values: state IDLE, req_ready=1, stall=0, resp_valid=0, resp_data=0, resp_rd=0, counter=0. Reset mid-op discards it with no response.
- States:
  - IDLE: req_ready=1.
  - CALC: one iteration per cycle; counter runs XLEN-1 down to 0.
  - FIX: sign correction and hi/lo selection.
  - DONE: resp_valid=1.
- IDLE to CALC on req_valid&&req_ready rising edge. The accept edge latches funct3, rd, |a|, |b| and the result-sign bits:
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - DIV/REM: signed.
  - Unsigned forms: no magnitude conversion.
- Multiply: 2*XLEN product register; each CALC cycle adds the multiplicand if the product LSB is set, then shifts right. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits after two's-complement negation of the full 2*XLEN product when the sign differs.
- Divide: restoring, one quotient bit per cycle, MSB first. The quotient is negated if the operand signs differ. The remainder takes the dividend's sign.
- CALC to FIX when counter==0. FIX to DONE unconditionally.
- Latency: resp_valid first high XLEN+2 cycles after the accept edge (34 for XLEN=32).
- Special cases, detected at accept; these go IDLE to DONE directly, with resp_valid high 1 cycle after accept:
  - Divide by zero (b==0): DIV/DIVU return all-ones; REM/REMU return a.
  - Signed overflow (DIV/REM, a==MIN, b==-1): DIV returns MIN; REM returns 0.
- DONE: resp_valid, resp_data and resp_rd are held stable until resp_ready. The resp_valid&&resp_ready edge returns to IDLE; req_ready rises the following cycle, so there is no same-cycle re-accept.
- stall = (state != IDLE). A req_valid arriving in the accept cycle is not stalled; stall takes effect the next cycle.
- flush has priority over every transition. In CALC/FIX/DONE it forces IDLE on the next edge and drops resp_valid with no handshake. In IDLE, flush blocks acceptance that cycle.
- req_valid with an unknown funct3 cannot occur; decode filters it.

Optional Feature:
- Macro: MULDIV_FUSE_EN.
- Defined:
  - After a divide completes, the block keeps the quotient, remainder, a, b and signedness in a one-entry cache.
  - A following DIV/REM (or DIVU/REMU) with identical a, b and signedness is a hit. It goes IDLE to DONE and returns the cached value, with resp_valid 1 cycle after accept.
  - Any multiply accept, flush or reset invalidates the cache.
- Undefined: no cache; every divide takes the full XLEN+2 latency.

Test Plan:
- MUL a=7, b=-3 -> resp_data=0xFFFFFFEB, resp_valid at cycle 34 after accept, stall high cycles 1..34.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU a=-1, b=2 -> 0xFFFFFFFF.
- DIV a=-20, b=3 -> 0xFFFFFFFA (-6). REM same operands -> 0xFFFFFFFE (-2). DIVU 100/7 -> 14. REMU -> 2.
- DIV a=5, b=0 -> 0xFFFFFFFF and REM a=5, b=0 -> 5, each 1 cycle after accept. DIV 0x80000000 by -1 -> 0x80000000; REM -> 0.
- Backpressure and flush:
  - Hold resp_ready=0 for 5 cycles in DONE -> resp_data/resp_rd stable, stall high.
  - Assert flush at CALC iteration 10 -> IDLE next cycle, no resp_valid, next op correct.
- With MULDIV_FUSE_EN: DIV 100/7 then REM 100/7 -> REM returns 2 in 1 cycle. DIV 100/7, MUL, REM 100/7 -> REM takes 34 cycles.
